// File: rtl/keypad_matrix_scanner.sv
// ----------------------------------------------------------------------------
// keypad_matrix_scanner
//
// Scans a ROWS x COLS active-low key matrix one row at a time. Each key has
// its own debouncer, so several keys can be held at once. Press and release
// events go into a small event FIFO that the UI FSM drains.
//
// Optional build macro: KEYPAD_REPEAT_EN adds auto-repeat for the most
// recently pressed key. Without it, evt_repeat is tied low.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   row           row drives; one bit low while scanning, all ones in reset
//   col           column sense inputs, active-low, asynchronous to clk
//   key_state     debounced pressed bitmap, bit r*COLS+c
//   any_key       OR of key_state
//   evt_valid     FIFO head valid
//   evt_ready     consumer ready
//   evt_code      head key code (r*COLS+c)
//   evt_press     head is a press (1) or a release (0)
//   evt_repeat    head is an auto-repeat press
//   evt_overflow  one-cycle pulse when an event is dropped because the FIFO is full
//
// Handshake: the head entry moves when evt_valid && evt_ready at a rising
// edge. While evt_valid is high and evt_ready is low, the head fields hold
// steady. A push and a pop in the same cycle are both accepted.
// ----------------------------------------------------------------------------
module keypad_matrix_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 12000,
    parameter int SETTLE_CYC     = 120,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 8,
    localparam int KW            = $clog2(ROWS * COLS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic [ROWS-1:0]        row,
    input  logic [COLS-1:0]        col,
    output logic [ROWS*COLS-1:0]   key_state,
    output logic                   any_key,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [KW-1:0]          evt_code,
    output logic                   evt_press,
    output logic                   evt_repeat,
    output logic                   evt_overflow
);
    localparam int NK = ROWS * COLS;
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef KEYPAD_REPEAT_EN
    localparam int EW = KW + 2;  // {repeat, press, code}
    localparam int REPEAT_DELAY = 30;
    localparam int REPEAT_RATE  = 6;
`else
    localparam int EW = KW + 1;  // {press, code}
`endif

    typedef enum logic [1:0] {S_DRIVE, S_SAMPLE, S_UPDATE, S_HOLD} state_t;

    state_t                  state_q, state_d;
    logic [SW-1:0]           slot_q, slot_d;
    logic [RW-1:0]           row_idx_q, row_idx_d, row_nxt;
    logic [CW-1:0]           col_idx_q, col_idx_d;
    logic [ROWS-1:0]         row_q, row_d;
    logic [COLS-1:0]         col_s1_q, col_s2_q, col_lat_q, col_lat_d;
    logic [NK-1:0]           key_state_q, key_state_d;
    logic                    any_key_q;
    logic [NK-1:0][3:0]      cnt_q, cnt_d;
    logic [KW-1:0]           key_idx;
    logic                    raw;
    logic                    push, push_press;
    logic [EW-1:0]           push_data;

    logic [FIFO_DEPTH-1:0][EW-1:0] mem_q;
    logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
    logic [AW:0]             count_q;
    logic                    full, pop, do_push, ovf_q;
    logic [EW-1:0]           head;

`ifdef KEYPAD_REPEAT_EN
    logic                    push_rep;
    logic                    trk_valid_q, trk_valid_d;
    logic [KW-1:0]           trk_key_q, trk_key_d;
    logic [5:0]              rep_cnt_q, rep_cnt_d;
    logic                    rep_first_q, rep_first_d;
`endif

    assign key_idx = KW'(row_idx_q) * KW'(COLS) + KW'(col_idx_q);
    assign raw     = ~col_lat_q[col_idx_q];
    assign row_nxt = (row_idx_q == RW'(ROWS - 1)) ? '0 : row_idx_q + RW'(1);

    always_comb begin
        state_d     = state_q;
        slot_d      = (slot_q == SW'(SCAN_DIV - 1)) ? '0 : slot_q + SW'(1);
        row_idx_d   = row_idx_q;
        col_idx_d   = col_idx_q;
        row_d       = row_q;
        col_lat_d   = col_lat_q;
        key_state_d = key_state_q;
        cnt_d       = cnt_q;
        push        = 1'b0;
        push_press  = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        push_rep    = 1'b0;
        trk_valid_d = trk_valid_q;
        trk_key_d   = trk_key_q;
        rep_cnt_d   = rep_cnt_q;
        rep_first_d = rep_first_q;
`endif
        case (state_q)
            S_DRIVE: begin
                row_d = ~(ROWS'(1) << row_idx_q);
                if (slot_q == SW'(SETTLE_CYC - 1)) state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                col_lat_d = col_s2_q;
                col_idx_d = '0;
                state_d   = S_UPDATE;
            end
            S_UPDATE: begin
                // Any frame where raw agrees with the debounced level restarts the count.
                if (raw == key_state_q[key_idx]) begin
                    cnt_d[key_idx] = '0;
                end else if (cnt_q[key_idx] == 4'(DEBOUNCE_SCANS - 1)) begin
                    key_state_d[key_idx] = raw;
                    cnt_d[key_idx]       = '0;
                    push                 = 1'b1;
                    push_press           = raw;
                end else begin
                    cnt_d[key_idx] = cnt_q[key_idx] + 4'd1;
                end
`ifdef KEYPAD_REPEAT_EN
                // At this point push is high only for a debounced flip of this key.
                if (push && push_press) begin
                    trk_valid_d = 1'b1;
                    trk_key_d   = key_idx;
                    rep_cnt_d   = '0;
                    rep_first_d = 1'b1;
                end else if (push) begin
                    if (trk_valid_q && trk_key_q == key_idx) trk_valid_d = 1'b0;
                end else if (trk_valid_q && trk_key_q == key_idx && key_state_q[key_idx]) begin
                    if (rep_cnt_q == (rep_first_q ? 6'(REPEAT_DELAY - 1) : 6'(REPEAT_RATE - 1))) begin
                        push        = 1'b1;
                        push_press  = 1'b1;
                        push_rep    = 1'b1;
                        rep_cnt_d   = '0;
                        rep_first_d = 1'b0;
                    end else begin
                        rep_cnt_d = rep_cnt_q + 6'd1;
                    end
                end
`endif
                if (col_idx_q == CW'(COLS - 1)) state_d = S_HOLD;
                else col_idx_d = col_idx_q + CW'(1);
            end
            S_HOLD: begin
                // Drive the next row on the same edge that re-enters DRIVE.
                if (slot_q == SW'(SCAN_DIV - 1)) begin
                    state_d   = S_DRIVE;
                    row_idx_d = row_nxt;
                    row_d     = ~(ROWS'(1) << row_nxt);
                end
            end
            default: state_d = S_DRIVE;
        endcase
    end

`ifdef KEYPAD_REPEAT_EN
    assign push_data = {push_rep, push_press, key_idx};
`else
    assign push_data = {push_press, key_idx};
`endif

    assign full    = (count_q == (AW + 1)'(FIFO_DEPTH));
    assign pop     = evt_valid & evt_ready;
    assign do_push = push & (~full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_DRIVE;
            slot_q      <= '0;
            row_idx_q   <= '0;
            col_idx_q   <= '0;
            row_q       <= '1;
            col_s1_q    <= '1;
            col_s2_q    <= '1;
            col_lat_q   <= '1;
            key_state_q <= '0;
            any_key_q   <= 1'b0;
            cnt_q       <= '0;
            mem_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            row_idx_q   <= row_idx_d;
            col_idx_q   <= col_idx_d;
            row_q       <= row_d;
            col_s1_q    <= col;
            col_s2_q    <= col_s1_q;
            col_lat_q   <= col_lat_d;
            key_state_q <= key_state_d;
            any_key_q   <= |key_state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= push & full & ~pop;
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef KEYPAD_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trk_valid_q <= 1'b0;
            trk_key_q   <= '0;
            rep_cnt_q   <= '0;
            rep_first_q <= 1'b1;
        end else begin
            trk_valid_q <= trk_valid_d;
            trk_key_q   <= trk_key_d;
            rep_cnt_q   <= rep_cnt_d;
            rep_first_q <= rep_first_d;
        end
    end
`endif

    assign head         = mem_q[rd_ptr_q];
    assign row          = row_q;
    assign key_state    = key_state_q;
    assign any_key      = any_key_q;
    assign evt_valid    = (count_q != '0);
    assign evt_code     = head[KW-1:0];
    assign evt_press    = head[KW];
`ifdef KEYPAD_REPEAT_EN
    assign evt_repeat   = head[KW+1];
`else
    assign evt_repeat   = 1'b0;
`endif
    assign evt_overflow = ovf_q;

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
- Parametrised successor to the single-key keypad scanner.
- Scans an ROWS x COLS active-low matrix row by row and debounces every key independently, so multi-key (n-key rollover) state is tracked.
- Press/release events are queued in an event FIFO with a valid/ready handshake.
- Sits between the board keypad pins and the UI/control FSM of the audio spectrum analyzer.

Parameters:
- ROWS, 4, number of driven row lines (2..8)
- COLS, 4, number of sensed column lines (2..8)
- SCAN_DIV, 12000, clk cycles per row slot; must be >= SETTLE_CYC + COLS + 2
- SETTLE_CYC, 120, cycles after row drive before columns are sampled
- DEBOUNCE_SCANS, 3, consecutive frames of opposite raw level needed to flip a key's debounced state (1..15)
- FIFO_DEPTH, 8, event FIFO entries (power of 2)
- KW, $clog2(ROWS*COLS), key code width (derived, localparam)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- row  out  ROWS  row drive; exactly one bit low while scanning, all ones in reset
- col  in  COLS  column sense, active-low, asynchronous to clk
- key_state  out  ROWS*COLS  debounced pressed bitmap; bit = r*COLS+c
- any_key  out  1  OR of key_state
- evt_valid  out  1  FIFO head valid
- evt_ready  in  1  consumer accepts head when evt_valid & evt_ready
- evt_code  out  KW  key code of head event (r*COLS+c)
- evt_press  out  1  1 = press event, 0 = release event
- evt_repeat  out  1  head event is an auto-repeat (see Optional Feature)
- evt_overflow  out  1  one-cycle pulse when an event is dropped

Behaviour:
- Reset (async, rst_n low): row=all ones; key_state=0; any_key=0; evt_valid=0; evt_code=0; evt_press=0; evt_repeat=0; evt_overflow=0; FIFO empty; debounce counters=0; FSM=DRIVE with row index 0.
- col passes through a 2-FF synchroniser before use; raw pressed = ~col_sync[c].
- Slot timing per row r, with slot counter 0..SCAN_DIV-1:
  - DRIVE: row[r]=0, others 1; wait SETTLE_CYC cycles.
  - SAMPLE: 1 cycle; latch col_sync.
  - UPDATE: COLS cycles, column c on cycle c; update debouncer of key r*COLS+c and push at most one event per cycle.
  - HOLD: until the slot counter reaches SCAN_DIV-1.
  - Then r advances by 1, wrapping ROWS-1 -> 0 (frame = ROWS*SCAN_DIV cycles). row changes in the same cycle as the DRIVE entry.
- Debouncer per key:
  - If raw == debounced, counter clears to 0.
  - Otherwise the counter increments. When it reaches DEBOUNCE_SCANS, the key_state bit flips, the counter clears, and an event is pushed: evt_press = new state.
  - Ghosting is not masked; all sampled keys are reported.
- key_state and any_key are registered and update in the UPDATE cycle following the flip.
- FIFO:
  - Push and pop in the same cycle are both honoured; occupancy is unchanged.
  - Push when full and no pop: the event is dropped, evt_overflow pulses 1 cycle, and key_state still flips.
  - evt_code/evt_press/evt_repeat are stable while evt_valid=1 and evt_ready=0.
  - Head data is don't-care when evt_valid=0.
- Latency: with a key held steadily from before a frame's SAMPLE, the press event reaches the FIFO during UPDATE of the DEBOUNCE_SCANS-th frame. evt_valid rises the next cycle if the FIFO was empty.
- Async reset mid-scan returns to the reset state immediately, releases all rows and discards queued events. No release events are generated for keys that were held.

Optional Feature:
- Macro KEYPAD_REPEAT_EN.
- Defined:
  - Tracks the most recently pressed key; a new press replaces it, and its release clears tracking.
  - After REPEAT_DELAY frames held (localparam 30), a press event with evt_repeat=1 is pushed during that key's UPDATE cycle, then every REPEAT_RATE frames (localparam 6).
  - Repeat events obey the same FIFO/overflow rules.
- Undefined: no repeat logic; evt_repeat tied 0.

Test Plan:
- ROWS=4, COLS=4, SCAN_DIV=16, SETTLE_CYC=4, DEBOUNCE_SCANS=3, FIFO_DEPTH=4 (frame=64 cycles).
- Hold key (1,2) low steadily -> after 3 frames: one event code=6, press=1; key_state=16'h0040; any_key=1. Release for 3 frames -> event code=6, press=0; key_state=0.
- Bounce (1,2) pressed 2 frames, released 1, pressed 2 -> no event, key_state stays 0.
- Hold (0,0) and (3,3) together -> two press events, codes 0 then 15 (scan order); key_state=16'h8001.
- evt_ready=0, press/release 3 distinct keys (6 events) -> 4 queued, evt_overflow pulses twice, key_state correct; head stable until ready=1 drains codes in order.
- Assert rst_n=0 mid-SAMPLE with events queued -> row=4'hF, evt_valid=0, key_state=0 immediately. With KEYPAD_REPEAT_EN, holding key 5 for 60 frames -> 1 press + repeats at frames 33, 39, 45, 51, 57 (evt_repeat=1).
